vga_frame_checker: RTL and testbench
====================================

Name: vga_frame_checker

Overview:
- Receiving end of the VGA output interface (vga_hs, vga_vs, vga_r/g/b) driven by the line-drawing display path.
- Sits in the testbench or on-chip debug path, clocked by the pixel clock.
- Locks to sync, measures horizontal/vertical timing, flags deviations from expected timing, and produces a per-frame pixel checksum and pixel count for regression comparison.

Parameters:
H_SYNC, 96, expected hs pulse width in clocks
H_BP, 48, back porch in clocks (hs trailing edge to first active pixel)
H_ACTIVE, 640, active pixels per line
H_TOTAL, 800, expected clocks per line
V_SYNC, 2, expected vs pulse width in lines
V_BP, 33, back porch in lines
V_ACTIVE, 480, active lines per frame
V_TOTAL, 525, expected lines per frame
SYNC_ACTIVE, 1'b0, asserted level of hs/vs (0 = active-low)
CHK_BITS, 32, checksum width

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
vga_hs  in  1  horizontal sync
vga_vs  in  1  vertical sync
vga_r  in  4  red
vga_g  in  4  green
vga_b  in  4  blue
locked  out  1  first frame start seen
frame_valid  out  1  one-cycle pulse; result outputs updated
frame_count  out  32  completed frames
meas_h_total  out  12  clocks in last completed line
meas_h_sync  out  12  hs width of last line
meas_v_total  out  11  lines in last frame
meas_v_sync  out  11  vs width in lines, last frame
pixel_count  out  20  active pixels sampled in last frame
checksum  out  CHK_BITS  pixel checksum of last frame
err_flags  out  4  sticky {v_sync, v_total, h_sync, h_total} mismatch

Behaviour:
- Reset (async, active-high): all outputs 0; state S_WAIT; all counters 0; input register holds deasserted sync levels.
- Input stage: hs, vs, rgb registered once (stage 1); edge detect compares stage 1 with stage 2. Leading edge = transition to SYNC_ACTIVE; trailing edge = transition away.
- hcount: 0 on cycle of hs leading edge, otherwise +1, saturating at 4095.
  - At hs leading edge: meas_h_total <= hcount+1 (previous line).
  - At hs trailing edge: meas_h_sync <= hcount.
- vs leading edge sets vs_pending. On the next hs leading edge (same cycle counts): vcount <= 0 and frame start fires. Other hs leading edges: vcount+1, saturating at 2047. vs trailing edge latches vs width = vcount+1 (lines).
- FSM:
  - S_WAIT: ignore pixels; first frame start -> S_RUN, locked <= 1; no frame_valid.
  - S_RUN: each frame start closes the previous frame:
    - frame_valid pulses 1 cycle.
    - meas_v_total <= vcount+1; meas_v_sync, pixel_count, checksum loaded from accumulators.
    - frame_count+1, wrapping at 2^32.
    - Accumulators clear in that same cycle; a pixel sampled that cycle belongs to the new frame.
  - No exit from S_RUN except reset.
- Active pixel: S_RUN and hcount in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and vcount in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
  - On each active pixel: acc_chk <= acc_chk + {r,g,b} zero-extended (mod 2^CHK_BITS); acc_pix+1.
- Errors, checked in S_RUN only:
  - h_total: evaluated at each hs leading edge after the first line following lock.
  - h_sync: evaluated at each hs trailing edge.
  - v_total, v_sync: evaluated at frame close.
  - Mismatch with the corresponding parameter sets the flag; flags are sticky until reset.
- Latency: frame_valid asserts 2 clocks after the raw hs edge that completes the frame start.
- Reset mid-frame: everything returns to S_WAIT; the partial frame is discarded.

Decomposition:
- Package vga_check_pkg: state enum (S_WAIT, S_RUN), error-bit index constants, default 640x480 timing constants.
- One sub-module, vga_sync_edge: register plus leading/trailing edge detect, parameterised by active level, instantiated for hs and vs.

Test Plan:
1. Small timing (H_SYNC=2, H_BP=2, H_ACTIVE=4, H_TOTAL=10, V_SYNC=1, V_BP=1, V_ACTIVE=3, V_TOTAL=6), constant rgb=12'h001, 3 frames -> first frame_valid after the 2nd vs; pixel_count=12, checksum=12, meas_h_total=10, meas_v_total=6, err_flags=0, frame_count=2.
2. Same, rgb = 12'hFFF -> checksum=12*4095=49140.
3. One line stretched to 11 clocks -> err_flags[0]=1 and remains set after later correct frames; other bits 0.
4. vs held 2 lines -> meas_v_sync=2, err_flags[3]=1.
5. Start stimulus mid-frame -> locked=0 and no frame_valid until the first vs; first reported frame fully correct.
6. Assert reset mid-frame of a running stream -> all outputs 0 immediately; relock on the next vs with correct counts.

Source files
------------

// File: rtl/vga_check_pkg.sv
// VGA frame checker shared types and defaults.
// Default timing below is standard 640x480 at 60 Hz.
package vga_check_pkg;

  typedef enum logic {
    S_WAIT,
    S_RUN
  } state_e;

  localparam int ERR_H_TOTAL = 0;
  localparam int ERR_H_SYNC  = 1;
  localparam int ERR_V_TOTAL = 2;
  localparam int ERR_V_SYNC  = 3;

  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_TOTAL  = 800;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_TOTAL  = 525;
  localparam int DEF_CHK_BITS = 32;

endpackage

// File: rtl/vga_sync_edge.sv
// Registers one sync input and flags its edges.
// lead = move to ACTIVE, trail = move away from it.
module vga_sync_edge
  import vga_check_pkg::*;
#(
  parameter logic ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic lead,
  output logic trail
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  // stage 1 samples the pin, stage 2 holds the prior sample
  always_comb begin
    s1_d = din;
    s2_d = s1_q;
  end

  // history flops start at the deasserted level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= ~ACTIVE;
      s2_q <= ~ACTIVE;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign lead  = (s1_q == ACTIVE) && (s2_q != ACTIVE);
  assign trail = (s1_q != ACTIVE) && (s2_q == ACTIVE);

endmodule

// File: rtl/vga_frame_checker.sv
// Locks to VGA sync, measures timing, flags deviations
// and reports a per-frame pixel checksum and count.
module vga_frame_checker
  import vga_check_pkg::*;
#(
  parameter int   H_SYNC      = DEF_H_SYNC,
  parameter int   H_BP        = DEF_H_BP,
  parameter int   H_ACTIVE    = DEF_H_ACTIVE,
  parameter int   H_TOTAL     = DEF_H_TOTAL,
  parameter int   V_SYNC      = DEF_V_SYNC,
  parameter int   V_BP        = DEF_V_BP,
  parameter int   V_ACTIVE    = DEF_V_ACTIVE,
  parameter int   V_TOTAL     = DEF_V_TOTAL,
  parameter logic SYNC_ACTIVE = 1'b0,
  parameter int   CHK_BITS    = DEF_CHK_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vga_hs,
  input  logic                vga_vs,
  input  logic [3:0]          vga_r,
  input  logic [3:0]          vga_g,
  input  logic [3:0]          vga_b,
  output logic                locked,
  output logic                frame_valid,
  output logic [31:0]         frame_count,
  output logic [11:0]         meas_h_total,
  output logic [11:0]         meas_h_sync,
  output logic [10:0]         meas_v_total,
  output logic [10:0]         meas_v_sync,
  output logic [19:0]         pixel_count,
  output logic [CHK_BITS-1:0] checksum,
  output logic [3:0]          err_flags
);

  localparam logic [11:0] H_MAX = 12'hFFF;
  localparam logic [10:0] V_MAX = 11'h7FF;
  localparam logic [11:0] H_LO  = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_HI  =
    12'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [10:0] V_LO  = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_HI  =
    11'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [11:0] H_TOT = 12'(H_TOTAL);
  localparam logic [11:0] H_SY  = 12'(H_SYNC);
  localparam logic [10:0] V_TOT = 11'(V_TOTAL);
  localparam logic [10:0] V_SY  = 11'(V_SYNC);

  logic hs_lead, hs_trail;
  logic vs_lead, vs_trail;

  vga_sync_edge #(.ACTIVE(SYNC_ACTIVE)) u_hs_edge (
    .clk   (clk),
    .reset (reset),
    .din   (vga_hs),
    .lead  (hs_lead),
    .trail (hs_trail)
  );

  vga_sync_edge #(.ACTIVE(SYNC_ACTIVE)) u_vs_edge (
    .clk   (clk),
    .reset (reset),
    .din   (vga_vs),
    .lead  (vs_lead),
    .trail (vs_trail)
  );

  state_e              state_q, state_d;
  logic [11:0]         rgb_q, rgb_d;
  logic [11:0]         hcount_q, hcount_d, hcount_nx;
  logic [10:0]         vcount_q, vcount_d, vcount_nx;
  logic                vs_pend_q, vs_pend_d;
  logic [10:0]         vs_width_q, vs_width_d;
  logic [CHK_BITS-1:0] acc_chk_q, acc_chk_d;
  logic [19:0]         acc_pix_q, acc_pix_d;
  logic                locked_q, locked_d;
  logic                fv_q, fv_d;
  logic [31:0]         frame_count_q, frame_count_d;
  logic [11:0]         meas_h_total_q, meas_h_total_d;
  logic [11:0]         meas_h_sync_q, meas_h_sync_d;
  logic [10:0]         meas_v_total_q, meas_v_total_d;
  logic [10:0]         meas_v_sync_q, meas_v_sync_d;
  logic [19:0]         pixel_count_q, pixel_count_d;
  logic [CHK_BITS-1:0] checksum_q, checksum_d;
  logic [3:0]          err_q, err_d;
  logic                fstart;
  logic                pix_act;

  // raster position; hcount_d is the count of this cycle
  always_comb begin
    rgb_d     = {vga_r, vga_g, vga_b};
    hcount_nx = (hcount_q == H_MAX) ? H_MAX
                                    : hcount_q + 12'd1;
    vcount_nx = (vcount_q == V_MAX) ? V_MAX
                                    : vcount_q + 11'd1;
    fstart    = hs_lead && (vs_pend_q || vs_lead);
    hcount_d  = hs_lead ? 12'd0 : hcount_nx;
    vcount_d  = vcount_q;
    if (hs_lead) begin
      vcount_d = fstart ? 11'd0 : vcount_nx;
    end
    vs_pend_d  = fstart ? 1'b0 : (vs_pend_q || vs_lead);
    vs_width_d = vs_trail ? vcount_nx : vs_width_q;
    pix_act    = (state_q == S_RUN)
              && (hcount_d >= H_LO) && (hcount_d <= H_HI)
              && (vcount_d >= V_LO) && (vcount_d <= V_HI);
  end

  // lock FSM, frame close, accumulators and error flags
  always_comb begin
    state_d        = state_q;
    locked_d       = locked_q;
    fv_d           = 1'b0;
    frame_count_d  = frame_count_q;
    meas_v_total_d = meas_v_total_q;
    meas_v_sync_d  = meas_v_sync_q;
    pixel_count_d  = pixel_count_q;
    checksum_d     = checksum_q;
    acc_chk_d      = acc_chk_q;
    acc_pix_d      = acc_pix_q;
    err_d          = err_q;
    meas_h_total_d = hs_lead ? hcount_nx : meas_h_total_q;
    meas_h_sync_d  = hs_trail ? hcount_d : meas_h_sync_q;
    if (fstart) begin
      acc_chk_d = '0;
      acc_pix_d = '0;
      unique case (state_q)
        S_WAIT: begin
          state_d  = S_RUN;
          locked_d = 1'b1;
        end
        S_RUN: begin
          fv_d           = 1'b1;
          meas_v_total_d = vcount_nx;
          meas_v_sync_d  = vs_width_q;
          pixel_count_d  = acc_pix_q;
          checksum_d     = acc_chk_q;
          frame_count_d  = frame_count_q + 32'd1;
        end
      endcase
    end
    if (pix_act) begin
      acc_chk_d = acc_chk_d + CHK_BITS'(rgb_q);
      acc_pix_d = acc_pix_d + 20'd1;
    end
    if (state_q == S_RUN) begin
      if (hs_lead && hcount_nx != H_TOT)
        err_d[ERR_H_TOTAL] = 1'b1;
      if (hs_trail && hcount_d != H_SY)
        err_d[ERR_H_SYNC] = 1'b1;
      if (fstart && vcount_nx != V_TOT)
        err_d[ERR_V_TOTAL] = 1'b1;
      if (fstart && vs_width_q != V_SY)
        err_d[ERR_V_SYNC] = 1'b1;
    end
  end

  // state and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_WAIT;
      rgb_q          <= '0;
      hcount_q       <= '0;
      vcount_q       <= '0;
      vs_pend_q      <= 1'b0;
      vs_width_q     <= '0;
      acc_chk_q      <= '0;
      acc_pix_q      <= '0;
      locked_q       <= 1'b0;
      fv_q           <= 1'b0;
      frame_count_q  <= '0;
      meas_h_total_q <= '0;
      meas_h_sync_q  <= '0;
      meas_v_total_q <= '0;
      meas_v_sync_q  <= '0;
      pixel_count_q  <= '0;
      checksum_q     <= '0;
      err_q          <= '0;
    end else begin
      state_q        <= state_d;
      rgb_q          <= rgb_d;
      hcount_q       <= hcount_d;
      vcount_q       <= vcount_d;
      vs_pend_q      <= vs_pend_d;
      vs_width_q     <= vs_width_d;
      acc_chk_q      <= acc_chk_d;
      acc_pix_q      <= acc_pix_d;
      locked_q       <= locked_d;
      fv_q           <= fv_d;
      frame_count_q  <= frame_count_d;
      meas_h_total_q <= meas_h_total_d;
      meas_h_sync_q  <= meas_h_sync_d;
      meas_v_total_q <= meas_v_total_d;
      meas_v_sync_q  <= meas_v_sync_d;
      pixel_count_q  <= pixel_count_d;
      checksum_q     <= checksum_d;
      err_q          <= err_d;
    end
  end

  assign locked       = locked_q;
  assign frame_valid  = fv_q;
  assign frame_count  = frame_count_q;
  assign meas_h_total = meas_h_total_q;
  assign meas_h_sync  = meas_h_sync_q;
  assign meas_v_total = meas_v_total_q;
  assign meas_v_sync  = meas_v_sync_q;
  assign pixel_count  = pixel_count_q;
  assign checksum     = checksum_q;
  assign err_flags    = err_q;

endmodule

// File: tb/tb_vga_frame_checker.sv
// Bench for vga_frame_checker on a tiny raster.
// A line/frame model predicts every reported frame.
module tb_vga_frame_checker;

  localparam int HS = 2;
  localparam int HB = 2;
  localparam int HA = 4;
  localparam int HT = 10;
  localparam int VS = 1;
  localparam int VB = 1;
  localparam int VA = 3;
  localparam int VT = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vga_hs = 1'b1;
  logic        vga_vs = 1'b1;
  logic [3:0]  vga_r = '0;
  logic [3:0]  vga_g = '0;
  logic [3:0]  vga_b = '0;
  logic        locked, frame_valid;
  logic [31:0] frame_count;
  logic [11:0] meas_h_total, meas_h_sync;
  logic [10:0] meas_v_total, meas_v_sync;
  logic [19:0] pixel_count;
  logic [31:0] checksum;
  logic [3:0]  err_flags;

  vga_frame_checker #(
    .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
    .SYNC_ACTIVE(1'b0), .CHK_BITS(32)
  ) dut (
    .clk(clk), .reset(reset),
    .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .locked(locked), .frame_valid(frame_valid),
    .frame_count(frame_count),
    .meas_h_total(meas_h_total),
    .meas_h_sync(meas_h_sync),
    .meas_v_total(meas_v_total),
    .meas_v_sync(meas_v_sync),
    .pixel_count(pixel_count),
    .checksum(checksum), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          pix;
    int unsigned chk;
    int          lines;
    int          vsw;
    int          hlen;
    int          hsw;
    logic [3:0]  err;
    int unsigned frames;
  } rec_t;

  rec_t        exp_q[$];
  rec_t        rec;
  int          n_chk, n_fail, n_fv, m_pushed;
  bit          m_locked, m_prev_vs;
  int          m_y, m_lines, m_vsw, m_pix;
  int unsigned m_chk, m_frames;
  int          prev_len, last_hsw;
  logic [3:0]  m_err;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_locked  = 1'b0;
    m_prev_vs = 1'b0;
    m_y       = 0;
    m_lines   = 0;
    m_vsw     = 0;
    m_pix     = 0;
    m_chk     = 0;
    m_frames  = 0;
    m_err     = '0;
    exp_q.delete();
  endtask

  // mode 0 random pixels, 1 = 12'h001, 2 = 12'hFFF
  task automatic drive_line(input int len, input int hsw,
                            input bit vs_on, input int mode);
    bit         rise;
    logic [11:0] p;
    if (m_locked && prev_len != HT) m_err[0] = 1'b1;
    rise = vs_on && !m_prev_vs;
    if (rise) begin
      if (m_locked) begin
        if (m_lines != VT) m_err[2] = 1'b1;
        if (m_vsw != VS) m_err[3] = 1'b1;
        m_frames++;
        m_pushed++;
        exp_q.push_back('{m_pix, m_chk, m_lines, m_vsw,
                          prev_len, last_hsw, m_err,
                          m_frames});
      end
      m_locked = 1'b1;
      m_y = 0; m_lines = 0; m_vsw = 0;
      m_pix = 0; m_chk = 0;
    end else if (m_locked) begin
      m_y++;
    end
    if (m_locked) begin
      m_lines++;
      if (vs_on) m_vsw++;
      if (hsw != HS) m_err[1] = 1'b1;
    end
    m_prev_vs = vs_on;
    for (int x = 0; x < len; x++) begin
      if (mode == 1) p = 12'h001;
      else if (mode == 2) p = 12'hFFF;
      else p = 12'($urandom);
      @(negedge clk);
      vga_hs = (x < hsw) ? 1'b0 : 1'b1;
      vga_vs = vs_on ? 1'b0 : 1'b1;
      {vga_r, vga_g, vga_b} = p;
      if (m_locked && m_y >= VS + VB
          && m_y < VS + VB + VA
          && x >= HS + HB && x < HS + HB + HA) begin
        m_pix++;
        m_chk += 32'(p);
      end
    end
    prev_len = len;
    last_hsw = hsw;
  endtask

  task automatic drive_frame(input int first, input int last,
                             input int mode, input int vs_lines,
                             input int stretch_y);
    for (int y = first; y <= last; y++) begin
      drive_line((y == stretch_y) ? HT + 1 : HT, HS,
                 y < vs_lines, mode);
    end
  endtask

  // compare every reported frame with the model's record
  always @(negedge clk) begin
    if (!reset && frame_valid) begin
      if (exp_q.size() == 0) begin
        check("frame_valid_unexpected", 1, 0);
      end else begin
        rec = exp_q.pop_front();
        n_fv++;
        check("pixel_count", pixel_count, rec.pix);
        check("checksum", checksum, rec.chk);
        check("meas_v_total", meas_v_total, rec.lines);
        check("meas_v_sync", meas_v_sync, rec.vsw);
        check("meas_h_total", meas_h_total, rec.hlen);
        check("meas_h_sync", meas_h_sync, rec.hsw);
        check("err_flags", err_flags, rec.err);
        check("frame_count", frame_count, rec.frames);
      end
    end
  end

  initial begin
    n_chk = 0; n_fail = 0; n_fv = 0; m_pushed = 0;
    prev_len = 0; last_hsw = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_locked", locked, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_checksum", checksum, 0);
    check("rst_pixel_count", pixel_count, 0);
    check("rst_err_flags", err_flags, 0);
    check("rst_meas_h_total", meas_h_total, 0);
    reset = 1'b0;

    // stream joins mid-frame: no lock before the first vs
    drive_frame(3, 5, 0, 1, -1);
    check("midframe_locked", locked, 0);

    // constant 12'h001
    repeat (3) drive_frame(0, 5, 1, 1, -1);
    check("t1_frame_count", frame_count, 2);
    check("t1_pixel_count", pixel_count, 12);
    check("t1_checksum", checksum, 12);
    check("t1_meas_h_total", meas_h_total, 10);
    check("t1_meas_v_total", meas_v_total, 6);
    check("t1_err_flags", err_flags, 0);
    check("t1_locked", locked, 1);

    // constant 12'hFFF
    repeat (2) drive_frame(0, 5, 2, 1, -1);
    check("t2_checksum", checksum, 49140);

    // random pixels
    repeat (4) drive_frame(0, 5, 0, 1, -1);

    // one line stretched to HT+1 clocks
    drive_frame(0, 5, 0, 1, $urandom_range(0, 5));
    repeat (2) drive_frame(0, 5, 0, 1, -1);
    check("t3_err_sticky", err_flags, 4'b0001);

    // vs held for two lines
    drive_frame(0, 5, 0, 2, -1);
    drive_frame(0, 1, 0, 1, -1);
    check("t4_meas_v_sync", meas_v_sync, 2);
    check("t4_err_flags", err_flags, 4'b1001);
    drive_frame(2, 5, 0, 1, -1);

    // reset in the middle of a frame
    drive_frame(0, 3, 0, 1, -1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_locked", locked, 0);
    check("mid_rst_frame_count", frame_count, 0);
    check("mid_rst_checksum", checksum, 0);
    check("mid_rst_pixel_count", pixel_count, 0);
    check("mid_rst_err_flags", err_flags, 0);
    check("mid_rst_meas_v_total", meas_v_total, 0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    drive_frame(4, 5, 0, 1, -1);
    check("relock_early", locked, 0);
    repeat (3) drive_frame(0, 5, 0, 1, -1);
    check("relock_frame_count", frame_count, 2);
    check("relock_err_flags", err_flags, 0);
    check("relock_meas_v_total", meas_v_total, 6);

    repeat (5) @(negedge clk);
    check("frames_pending", exp_q.size(), 0);
    check("frames_seen", n_fv, m_pushed);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
